dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory (1024 × 32-bit words). It shares the memory between the DSP core load/store unit and the DMA engine, issuing at most one access per cycle. It registers read data into per-requester response channels and range-checks addresses. Core has fixed priority, and a bounded-wait counter guarantees DMA forward progress.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter and sequencer for a single-ported data memory: core has fixed priority,
// a bounded wait counter forces DMA through. Range checking is enabled by DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [31:0]       core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_err_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [31:0]       dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic [3:0]        dma_wait_q, dma_wait_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_rvalid_q, core_err_q, dma_rvalid_q, dma_err_q;
  logic [DATA_W-1:0] core_rdata_q, dma_rdata_q;

  logic              core_gnt_s, dma_gnt_s, any_gnt_s;
  logic              sel_we_s, in_range_s;
  logic [31:0]       sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s, rsp_data_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^{core_addr_i[31:ADDR_W], dma_addr_i[31:ADDR_W]};

  // Arbitration, access selection and memory-side drive
  always_comb begin
    core_gnt_s = 1'b0;
    dma_gnt_s  = 1'b0;
    if (!rst_n) begin
      core_gnt_s = 1'b0;
      dma_gnt_s  = 1'b0;
    end else if (dma_req_i && (!core_req_i || (dma_wait_q == 4'(MAX_WAIT)))) begin
      dma_gnt_s = 1'b1;
    end else if (core_req_i) begin
      core_gnt_s = 1'b1;
    end else begin
      core_gnt_s = 1'b0;
      dma_gnt_s  = 1'b0;
    end

    any_gnt_s   = core_gnt_s | dma_gnt_s;
    sel_we_s    = dma_gnt_s ? dma_we_i    : core_we_i;
    sel_addr_s  = dma_gnt_s ? dma_addr_i  : core_addr_i;
    sel_wdata_s = dma_gnt_s ? dma_wdata_i : core_wdata_i;

`ifdef DMEM_ARB_RANGE_CHK_EN
    in_range_s = (sel_addr_s < 32'(DEPTH));
`else
    in_range_s = 1'b1;
`endif

    // Out-of-range accesses report zero data rather than whatever the memory returns.
    rsp_data_s  = in_range_s ? mem_rdata_i : {DATA_W{1'b0}};
    mem_we_o    = any_gnt_s & sel_we_s & in_range_s;
    mem_addr_o  = any_gnt_s ? sel_addr_s[ADDR_W-1:0] : mem_addr_q;
    mem_wdata_o = any_gnt_s ? sel_wdata_s : mem_wdata_q;
  end

  // DMA lost-contention counter, saturating so it can never wrap past MAX_WAIT
  always_comb begin
    dma_wait_d = dma_wait_q;
    if (!dma_req_i || dma_gnt_s) begin
      dma_wait_d = 4'd0;
    end else if (dma_wait_q != 4'hF) begin
      dma_wait_d = dma_wait_q + 4'd1;
    end else begin
      dma_wait_d = dma_wait_q;
    end
  end

  // Wait counter, last memory address/data and per-requester response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_wait_q    <= 4'd0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
      core_rdata_q  <= {DATA_W{1'b0}};
      dma_rvalid_q  <= 1'b0;
      dma_err_q     <= 1'b0;
      dma_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      dma_wait_q <= dma_wait_d;
      if (any_gnt_s) begin
        mem_addr_q  <= sel_addr_s[ADDR_W-1:0];
        mem_wdata_q <= sel_wdata_s;
      end
      core_rvalid_q <= core_gnt_s;
      core_err_q    <= core_gnt_s & ~in_range_s;
      dma_rvalid_q  <= dma_gnt_s;
      dma_err_q     <= dma_gnt_s & ~in_range_s;
      // Successful writes leave the previous read data on the response channel.
      if (core_gnt_s && (!core_we_i || !in_range_s)) begin
        core_rdata_q <= rsp_data_s;
      end
      if (dma_gnt_s && (!dma_we_i || !in_range_s)) begin
        dma_rdata_q <= rsp_data_s;
      end
    end
  end

  assign core_gnt_o    = core_gnt_s;
  assign dma_gnt_o     = dma_gnt_s;
  assign core_rvalid_o = core_rvalid_q;
  assign core_err_o    = core_err_q;
  assign core_rdata_o  = core_rdata_q;
  assign dma_rvalid_o  = dma_rvalid_q;
  assign dma_err_o     = dma_err_q;
  assign dma_rdata_o   = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of grants, responses and memory contents.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dma_since = 0;
  logic        dma_pending, m_cg, m_dg, obs_dg, obs_mwe;
  logic        exp_c_rv, exp_d_rv, exp_c_err, exp_d_err;
  logic [31:0] exp_c_rd, exp_d_rd, exp_mwd;
  logic [9:0]  exp_maddr;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );

  // Memory behind the arbiter: combinational read, write on the rising edge
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return !RANGE_CHK || (a < 32'd1024);
  endfunction

  // Response to a granted access: {err, rdata}
  function automatic logic [32:0] rsp(input logic we, input logic [31:0] a, input logic [31:0] prev);
    if (!in_rng(a)) return {1'b1, 32'd0};
    if (we) return {1'b0, prev};
    return {1'b0, ref_mem[a[9:0]]};
  endfunction

  task automatic model_reset();
    exp_c_rv = 1'b0; exp_d_rv = 1'b0; exp_c_err = 1'b0; exp_d_err = 1'b0;
    exp_c_rd = 32'd0; exp_d_rd = 32'd0; exp_mwd = 32'd0; exp_maddr = 10'd0;
    dma_pending = 1'b0; m_cg = 1'b0; m_dg = 1'b0;
  endtask

  // One clock of traffic: check this cycle's outputs, then advance the model at the edge
  task automatic step();
    logic cg, dg, gwe, rng;
    logic [31:0] ga, gwd;
    logic [32:0] r;
    @(negedge clk);
    if (dma_req && !dma_pending) dma_since = cyc;
    dg  = dma_req && (!core_req || (cyc - dma_since) >= MAX_WAIT);
    cg  = core_req && !dg;
    ga  = dg ? dma_addr : core_addr;
    gwe = dg ? dma_we : core_we;
    gwd = dg ? dma_wdata : core_wdata;
    rng = in_rng(ga);
    if (cg || dg) begin
      exp_maddr = ga[9:0];
      exp_mwd   = gwd;
    end
    obs_dg  = dma_gnt;
    obs_mwe = mem_we;
    chk("core_gnt", 32'(core_gnt), 32'(cg));
    chk("dma_gnt", 32'(dma_gnt), 32'(dg));
    chk("mem_we", 32'(mem_we), 32'((cg || dg) && gwe && rng));
    chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
    chk("mem_wdata", mem_wdata, exp_mwd);
    chk("core_rvalid", 32'(core_rvalid), 32'(exp_c_rv));
    chk("core_rdata", core_rdata, exp_c_rd);
    if (exp_c_rv) chk("core_err", 32'(core_err), 32'(exp_c_err));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(exp_d_rv));
    chk("dma_rdata", dma_rdata, exp_d_rd);
    if (exp_d_rv) chk("dma_err", 32'(dma_err), 32'(exp_d_err));
    @(posedge clk);
    exp_c_rv = cg;
    exp_d_rv = dg;
    if (cg) begin r = rsp(gwe, ga, exp_c_rd); exp_c_err = r[32]; exp_c_rd = r[31:0]; end
    if (dg) begin r = rsp(gwe, ga, exp_d_rd); exp_d_err = r[32]; exp_d_rd = r[31:0]; end
    if ((cg || dg) && gwe && rng) ref_mem[ga[9:0]] = gwd;
    dma_pending = dma_req && !dg;
    m_cg = cg;
    m_dg = dg;
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 32'd1024 + $urandom_range(0, 31);
    if (sel == 1) return $urandom;
    return $urandom_range(0, 31);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = (i < 4) ? 32'(10 + i) : (32'hA5A5_0000 ^ 32'(i));
      ref_mem[i] = tb_mem[i];
    end
    model_reset();
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'd0; core_wdata = 32'd1;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'd0; dma_wdata  = 32'd2;

    // Reset state, with requests asserted across a clock edge
    #7;
    chk("rst_core_gnt", 32'(core_gnt), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_core_err", 32'(core_err), 32'd0);
    chk("rst_dma_err", 32'(dma_err), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    core_req = 1'b0; dma_req = 1'b0;
    #4 rst_n = 1'b1;
    step();

    // Core write then read-back of the same word
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'd5; core_wdata = 32'hDEADBEEF;
    step();
    chk("wr5_mem_we", 32'(obs_mwe), 32'd1);
    core_we = 1'b0;
    step();
    chk("rd5_rvalid", 32'(core_rvalid), 32'd1);
    chk("rd5_rdata", core_rdata, 32'hDEADBEEF);
    core_req = 1'b0;
    step();

    // Continuous contention: DMA forced through every MAX_WAIT+1 cycles
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'd9;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'd20;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("dma_pattern", 32'(obs_dg), 32'((i % 5) == 4));
      if (m_cg) core_addr = $urandom_range(0, 15);
    end
    core_req = 1'b0; dma_req = 1'b0;
    step();

    // DMA-only read burst over the preloaded words
    dma_req = 1'b1; dma_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dma_addr = 32'(i);
      step();
      chk("burst_gnt", 32'(obs_dg), 32'd1);
      chk("burst_rvalid", 32'(dma_rvalid), 32'd1);
      chk("burst_rdata", dma_rdata, 32'(10 + i));
    end
    dma_req = 1'b0;
    step();

    // Write just past the end of memory
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'd1024; core_wdata = 32'h1234_5678;
    step();
    chk("oor_mem_we", 32'(obs_mwe), 32'(!RANGE_CHK));
    chk("oor_err", 32'(core_err), 32'(RANGE_CHK));
    core_we = 1'b0; core_addr = 32'd0;
    step();
    chk("oor_word0", core_rdata, RANGE_CHK ? 32'd10 : 32'h1234_5678);
    core_req = 1'b0;
    step();

    // Simultaneous core read and DMA write to the same word
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'd7;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'd7; dma_wdata = 32'hCAFE_F00D;
    step();
    chk("same_core_old", core_rdata, 32'hA5A5_0007);
    core_req = 1'b0;
    step();
    chk("same_dma_we", 32'(obs_mwe), 32'd1);
    chk("same_dma_rvalid", 32'(dma_rvalid), 32'd1);
    dma_req = 1'b0; core_req = 1'b1;
    step();
    chk("same_core_new", core_rdata, 32'hCAFE_F00D);

    // Reset between a read grant and its response
    core_addr = 32'd3;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(core_rvalid), 32'd0);
    chk("midrst_rdata", core_rdata, 32'd0);
    chk("midrst_gnt", 32'(core_gnt), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    core_req = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    step();
    chk("postrst_rvalid", 32'(core_rvalid), 32'd0);

    // Random traffic honouring the hold-until-granted rule
    for (int n = 0; n < 400; n++) begin
      if (!core_req || m_cg) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = rand_addr();
        core_wdata = $urandom;
      end
      if (!dma_req || m_dg) begin
        dma_req   = ($urandom_range(0, 3) != 0);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = rand_addr();
        dma_wdata = $urandom;
      end
      step();
    end
    core_req = 1'b0; dma_req = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
